// File: rtl/rf_pkg.sv
// Shared definitions for the scoreboarded register file: default sizes,
// a safe address-width helper and the word/address types.
package rf_pkg;

   localparam int XLEN_DEF  = 32;
   localparam int NREGS_DEF = 32;

   // Address width for n registers, never narrower than one bit.
   function automatic int addr_w(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

   localparam int AW_DEF = addr_w(NREGS_DEF);

   typedef logic [AW_DEF-1:0]   reg_addr_t;
   typedef logic [XLEN_DEF-1:0] xword_t;

endpackage

// File: rtl/rf_bypass_mux.sv
// One read port: zero register, then same-cycle write forwarding (highest
// write port wins), then the stored value. Also produces the operand-ready
// flag from the scoreboard bit of the addressed register.
module rf_bypass_mux
   import rf_pkg::*;
#(
   parameter int XLEN     = XLEN_DEF,
   parameter int AW       = AW_DEF,
   parameter int NWR      = 2,
   parameter int ZERO_REG = 1
) (
   input  logic [AW-1:0]       rd_addr_i,
   input  logic [XLEN-1:0]     arr_data_i,
   input  logic                pend_i,
   input  logic [NWR-1:0]      wr_en_i,
   input  logic [NWR*AW-1:0]   wr_addr_i,
   input  logic [NWR*XLEN-1:0] wr_data_i,
   output logic [XLEN-1:0]     rd_data_o,
   output logic                rd_ready_o
);

   logic            fwd_hit;
   logic [XLEN-1:0] fwd_data;

   // Scan write ports in ascending order so the highest matching port is kept.
   always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = arr_data_i;
      for (int p = 0; p < NWR; p++) begin
         if (wr_en_i[p] && (wr_addr_i[p*AW +: AW] == rd_addr_i)) begin
            fwd_hit  = 1'b1;
            fwd_data = wr_data_i[p*XLEN +: XLEN];
         end
      end
   end

   // Final select: hardwired zero overrides forwarding and storage.
   always_comb begin
      rd_data_o  = fwd_data;
      rd_ready_o = fwd_hit | ~pend_i;
      if ((ZERO_REG != 0) && (rd_addr_i == '0)) begin
         rd_data_o  = '0;
         rd_ready_o = 1'b1;
      end
   end

endmodule

// File: rtl/regfile_sb.sv
// Multi-ported register file with write-to-read bypass and a per-register
// pending scoreboard for RAW hazard detection in decode/issue.
module regfile_sb
   import rf_pkg::*;
#(
   parameter  int XLEN     = XLEN_DEF,
   parameter  int NREGS    = NREGS_DEF,
   parameter  int NRD      = 2,
   parameter  int NWR      = 2,
   parameter  int ZERO_REG = 1,
   localparam int AW       = addr_w(NREGS),
   localparam int CW       = $clog2(NREGS + 1)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NRD*AW-1:0]   rd_addr,
   output logic [NRD*XLEN-1:0] rd_data,
   output logic [NRD-1:0]      rd_ready,
   input  logic [NWR-1:0]      wr_en,
   input  logic [NWR*AW-1:0]   wr_addr,
   input  logic [NWR*XLEN-1:0] wr_data,
   input  logic                alloc_en,
   input  logic [AW-1:0]       alloc_addr,
   input  logic                flush,
   output logic [CW-1:0]       pending_cnt
);

   logic [XLEN-1:0]  rf_q [NREGS];
   logic [NREGS-1:0] pend_q;
   logic [NREGS-1:0] pend_d;
   logic [NREGS-1:0] wr_hit;
   logic [CW-1:0]    cnt_q;
   logic [CW-1:0]    cnt_d;

   // Storage: later write ports overwrite earlier ones on an address clash;
   // writes to the hardwired zero register are discarded.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < NREGS; r++) begin
            rf_q[r] <= '0;
         end
      end else begin
         for (int p = 0; p < NWR; p++) begin
            if (wr_en[p] && !((ZERO_REG != 0) && (wr_addr[p*AW +: AW] == '0))) begin
               rf_q[wr_addr[p*AW +: AW]] <= wr_data[p*XLEN +: XLEN];
            end
         end
      end
   end

   // Per-register flag: some write port targets this register this cycle.
   always_comb begin
      wr_hit = '0;
      for (int r = 0; r < NREGS; r++) begin
         for (int p = 0; p < NWR; p++) begin
            if (wr_en[p] && (wr_addr[p*AW +: AW] == AW'(r))) begin
               wr_hit[r] = 1'b1;
            end
         end
      end
   end

   // Scoreboard next state (flush > alloc > writeback clear) and its popcount.
   always_comb begin
      pend_d = pend_q;
      cnt_d  = '0;
      for (int r = 0; r < NREGS; r++) begin
         if (flush) begin
            pend_d[r] = 1'b0;
         end else if (alloc_en && (alloc_addr == AW'(r))) begin
            pend_d[r] = 1'b1;
         end else if (wr_hit[r]) begin
            pend_d[r] = 1'b0;
         end
      end
      if (ZERO_REG != 0) begin
         pend_d[0] = 1'b0;
      end
      for (int r = 0; r < NREGS; r++) begin
         cnt_d = cnt_d + CW'(pend_d[r]);
      end
   end

   // Scoreboard and pending-count registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_q <= '0;
         cnt_q  <= '0;
      end else begin
         pend_q <= pend_d;
         cnt_q  <= cnt_d;
      end
   end

   assign pending_cnt = cnt_q;

   for (genvar i = 0; i < NRD; i++) begin : g_rd
      logic [AW-1:0]   addr;
      logic [XLEN-1:0] arr_data;
      logic            pend;

      assign addr     = rd_addr[i*AW +: AW];
      assign arr_data = rf_q[addr];
      assign pend     = pend_q[addr];

      rf_bypass_mux #(
         .XLEN     (XLEN),
         .AW       (AW),
         .NWR      (NWR),
         .ZERO_REG (ZERO_REG)
      ) u_mux (
         .rd_addr_i  (addr),
         .arr_data_i (arr_data),
         .pend_i     (pend),
         .wr_en_i    (wr_en),
         .wr_addr_i  (wr_addr),
         .wr_data_i  (wr_data),
         .rd_data_o  (rd_data[i*XLEN +: XLEN]),
         .rd_ready_o (rd_ready[i])
      );
   end

endmodule
